// File: rtl/ariane_pkg.sv
// Shared frontend types for the branch history table and its update sequencer.
package ariane_pkg;

   localparam int unsigned VLEN            = 64;
   localparam int unsigned INSTR_PER_FETCH = 2;

   // Counter value written into every column by a row clear (weakly taken).
   localparam logic [1:0] BHT_CTR_INIT = 2'b10;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic            taken;
   } bht_update_t;

   typedef enum logic {FLUSH, RUN} bht_ctrl_state_e;

endpackage

// File: rtl/bht_upd_queue.sv
// Multi-push, single-pop update FIFO. Valid ports are packed into consecutive slots.
module bht_upd_queue
   import ariane_pkg::*;
#(
   parameter int unsigned NR_REQ = 2,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  logic [NR_REQ-1:0]            push_valid_i,
   input  bht_update_t [NR_REQ-1:0]     push_data_i,
   input  logic                         pop_i,
   output bht_update_t                  head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   bht_update_t     mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic [CntW-1:0] n_push;
   logic [PtrW-1:0] waddr [NR_REQ];

   // Each valid port lands after all lower-indexed valid ports.
   always_comb begin
      n_push = '0;
      for (int i = 0; i < int'(NR_REQ); i++) begin
         waddr[i] = wr_ptr_q + n_push[PtrW-1:0];
         n_push   = n_push + CntW'(push_valid_i[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_i) wr_ptr_q <= wr_ptr_q + n_push[PtrW-1:0];
         count_q <= count_q - CntW'(pop_i) + (push_i ? n_push : '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) begin
         for (int i = 0; i < int'(NR_REQ); i++) begin
            if (push_valid_i[i]) mem_q[waddr[i]] <= push_data_i[i];
         end
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bht_ctrl.sv
// BHT sequencer: row-by-row clear walk, update merge queue and global history register.
module bht_ctrl
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES  = 1024,
   parameter int unsigned NR_REQ      = 2,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            flush_i,
   input  logic                                            debug_mode_i,
   input  logic [NR_REQ-1:0]                               req_valid_i,
   input  bht_update_t [NR_REQ-1:0]                        req_update_i,
   output logic                                            req_ready_o,
   output bht_update_t                                     bht_update_o,
   output logic                                            clr_valid_o,
   output logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0]   clr_row_o,
   output logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0]   ghr_o,
   output logic                                            busy_o
);

   localparam int unsigned NrRows = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned RW     = $clog2(NrRows);
   localparam int unsigned CntW   = $clog2(QUEUE_DEPTH + 1);
   localparam logic [RW-1:0] LastRow = RW'(NrRows - 1);

   bht_ctrl_state_e state_q;
   logic [RW-1:0]   row_q, ghr_q;
   bht_update_t     head;
   logic [CntW-1:0] count;
   logic            running, issue, push;

   assign running = (state_q == RUN);
   assign issue   = running && (count != '0);

   // Free slots include the slot vacated by this cycle's issue.
   assign req_ready_o = running &&
      ((int'(QUEUE_DEPTH) - int'(count) + int'(issue)) >= int'(NR_REQ));
   assign push = req_ready_o && (|req_valid_i) && !debug_mode_i;

   bht_upd_queue #(
      .NR_REQ (NR_REQ),
      .DEPTH  (QUEUE_DEPTH)
   ) u_queue (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (flush_i),
      .push_i       (push),
      .push_valid_i (req_valid_i),
      .push_data_i  (req_update_i),
      .pop_i        (issue),
      .head_o       (head),
      .count_o      (count)
   );

   always_comb begin
      bht_update_o = '0;
      if (issue) begin
         bht_update_o       = head;
         bht_update_o.valid = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FLUSH;
         row_q   <= '0;
         ghr_q   <= '0;
      end else begin
         unique case (state_q)
            FLUSH: begin
               ghr_q <= '0;
               if (flush_i) begin
                  row_q <= '0;
               end else if (row_q == LastRow) begin
                  row_q   <= '0;
                  state_q <= RUN;
               end else begin
                  row_q <= row_q + 1'b1;
               end
            end
            RUN: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  row_q   <= '0;
                  ghr_q   <= '0;
               end else if (issue) begin
                  ghr_q <= {ghr_q[RW-2:0], head.taken};
               end
            end
            default: state_q <= FLUSH;
         endcase
      end
   end

   assign clr_valid_o = !running;
   assign busy_o      = !running;
   assign clr_row_o   = row_q;
   assign ghr_o       = ghr_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// Bench for bht_ctrl: directed vector table plus random traffic against a queue-based model.
module tb_bht_ctrl;
   import ariane_pkg::*;

   localparam int unsigned NrEntries = 1024;
   localparam int unsigned NrReq     = 2;
   localparam int unsigned QDepth    = 4;
   localparam int unsigned Rows      = NrEntries / INSTR_PER_FETCH;
   localparam int unsigned RW        = $clog2(Rows);

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic                       flush = 1'b0;
   logic                       dbg = 1'b0;
   logic [NrReq-1:0]           req_valid = '0;
   bht_update_t [NrReq-1:0]    req_update = '0;
   logic                       req_ready;
   bht_update_t                bht_update;
   logic                       clr_valid;
   logic [RW-1:0]              clr_row;
   logic [RW-1:0]              ghr;
   logic                       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bht_ctrl #(
      .NR_ENTRIES  (NrEntries),
      .NR_REQ      (NrReq),
      .QUEUE_DEPTH (QDepth)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .debug_mode_i (dbg),
      .req_valid_i  (req_valid),
      .req_update_i (req_update),
      .req_ready_o  (req_ready),
      .bht_update_o (bht_update),
      .clr_valid_o  (clr_valid),
      .clr_row_o    (clr_row),
      .ghr_o        (ghr),
      .busy_o       (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Reference model: walking flag + row, FIFO of pending updates, history as an integer.
   typedef struct {
      logic [63:0] pc;
      logic        taken;
   } ent_t;

   ent_t mq[$];
   bit   m_fl;
   int   m_row;
   int   m_ghr;

   task automatic model_reset();
      m_fl  = 1'b1;
      m_row = 0;
      m_ghr = 0;
      mq.delete();
   endtask

   task automatic model_cycle();
      bit iss, rdy;
      int free;
      ent_t e;
      iss  = !m_fl && (mq.size() > 0);
      free = int'(QDepth) - mq.size() + (iss ? 1 : 0);
      rdy  = !m_fl && (free >= int'(NrReq));
      chk("busy", busy, m_fl);
      chk("clr_valid", clr_valid, m_fl);
      if (m_fl) chk("clr_row", clr_row, m_row);
      chk("ready", req_ready, rdy);
      chk("upd_valid", bht_update.valid, iss);
      if (iss) begin
         chk("upd_pc", bht_update.pc, mq[0].pc);
         chk("upd_taken", bht_update.taken, mq[0].taken);
      end
      chk("ghr", ghr, m_ghr);
      if (m_fl) begin
         if (flush) m_row = 0;
         else if (m_row == int'(Rows) - 1) begin
            m_fl  = 1'b0;
            m_row = 0;
         end else m_row++;
      end else begin
         if (iss) begin
            m_ghr = ((m_ghr << 1) | int'(mq[0].taken)) & (int'(Rows) - 1);
            void'(mq.pop_front());
         end
         if (rdy && (req_valid != '0) && !dbg) begin
            for (int i = 0; i < int'(NrReq); i++) begin
               if (req_valid[i]) begin
                  e.pc    = req_update[i].pc;
                  e.taken = req_update[i].taken;
                  mq.push_back(e);
               end
            end
         end
         if (flush) begin
            m_fl  = 1'b1;
            m_row = 0;
            m_ghr = 0;
            mq.delete();
         end
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic t0,
                        input logic [63:0] p1, input logic t1, input logic d, input logic f);
      req_valid           = v;
      req_update[0].valid = 1'b0;
      req_update[0].pc    = p0;
      req_update[0].taken = t0;
      req_update[1].valid = 1'b0;
      req_update[1].pc    = p1;
      req_update[1].taken = t1;
      dbg                 = d;
      flush               = f;
   endtask

   task automatic cycle();
      #1;
      model_cycle();
      @(negedge clk);
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [63:0] p0;
      logic        t0;
      logic [63:0] p1;
      logic        t1;
      logic        d;
      logic        f;
      logic        e_busy;
      logic        e_ready;
      logic        e_valid;
      logic [63:0] e_pc;
      logic [8:0]  e_ghr;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // v, p0, t0, p1, t1, dbg, flush | busy, ready, valid, pc, ghr
      tbl.push_back('{2'd3, 64'h100, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h000});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100, 9'h000});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h200, 9'h001});
      tbl.push_back('{2'd2, 64'h0,   1'b0, 64'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h002});
      tbl.push_back('{2'd1, 64'h400, 1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h300, 9'h002});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h400, 9'h005});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h00A});
      tbl.push_back('{2'd1, 64'h500, 1'b1, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h00A});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h00A});
      tbl.push_back('{2'd3, 64'h600, 1'b0, 64'h610, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h00A});
      tbl.push_back('{2'd3, 64'h620, 1'b0, 64'h630, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h600, 9'h00A});
      tbl.push_back('{2'd3, 64'h640, 1'b0, 64'h650, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h610, 9'h014});
      tbl.push_back('{2'd3, 64'h660, 1'b1, 64'h670, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h620, 9'h029});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h630, 9'h052});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h640, 9'h0A4});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h650, 9'h148});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h090});
      tbl.push_back('{2'd3, 64'h700, 1'b1, 64'h710, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   9'h090});
      tbl.push_back('{2'd3, 64'h720, 1'b0, 64'h730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h700, 9'h090});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h710, 9'h121});
      tbl.push_back('{2'd0, 64'h0,   1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,   9'h000});

      // Reset values.
      model_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b1);
      chk("rst_clr_valid", clr_valid, 1'b1);
      chk("rst_clr_row", clr_row, 0);
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_upd_valid", bht_update.valid, 1'b0);
      chk("rst_upd_pc", bht_update.pc, 64'h0);
      chk("rst_upd_taken", bht_update.taken, 1'b0);
      chk("rst_ghr", ghr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Power-up walk over all rows.
      drive(2'd0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < int'(Rows); c++) cycle();

      // Directed vectors, starting at the first RUN cycle.
      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].p0, tbl[k].t0, tbl[k].p1, tbl[k].t1, tbl[k].d, tbl[k].f);
         #1;
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
         chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].e_ready);
         chk($sformatf("tbl%0d_valid", k), bht_update.valid, tbl[k].e_valid);
         if (tbl[k].e_valid) chk($sformatf("tbl%0d_pc", k), bht_update.pc, tbl[k].e_pc);
         chk($sformatf("tbl%0d_ghr", k), ghr, tbl[k].e_ghr);
         model_cycle();
         @(negedge clk);
      end

      // Let the flush walk complete.
      drive(2'd0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < int'(Rows); c++) cycle();

      // Random traffic with occasional debug mode and flushes.
      for (int c = 0; c < 1500; c++) begin
         drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
         cycle();
      end

      // Asynchronous reset in the middle of a walk.
      drive(2'd0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(2'd0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < int'(Rows) && m_row != 100; c++) cycle();
      #1;
      chk("mid_walk_row", clr_row, 100);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_row", clr_row, 0);
      chk("async_rst_busy", busy, 1'b1);
      chk("async_rst_ready", req_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 8; c++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
